// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad front end: drives one active-low column at a time and debounces
// whole scans. It presents one committed key code with a 0 gap between different keys.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV       = 100000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] decode,
   output logic       pressed,
   output logic       multi
);

   localparam int unsigned DivW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned StabW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DivW-1:0]  DivLast = DivW'(SCAN_DIV - 1);
   localparam logic [StabW-1:0] StabMax = StabW'(DEBOUNCE_SCANS);

   // Indexed by {row, column}
   localparam logic [3:0] KeyMap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                          4'h4, 4'h5, 4'h6, 4'hB,
                                          4'h7, 4'h8, 4'h9, 4'hC,
                                          4'h0, 4'hF, 4'hE, 4'hD};

   typedef enum logic [1:0] {ResNone, ResKey, ResMulti} res_kind_e;
   typedef enum logic [1:0] {StIdleOut, StHeld, StGap} state_e;

   logic [DivW-1:0]  div_q;
   logic [1:0]       col_idx_q;
   logic [3:0]       col_q;
   logic [1:0]       acc_cnt_q;
   logic [3:0]       acc_code_q;
   res_kind_e        last_kind_q;
   logic [3:0]       last_code_q;
   logic [StabW-1:0] stable_q;
   state_e           state_q;
   logic [3:0]       decode_q;
   logic             pressed_q;
   logic             multi_q;
   logic [3:0]       pend_q;

   logic [1:0]       scan_cnt;
   logic [3:0]       scan_code;
   res_kind_e        res_kind;
   logic [3:0]       res_code;
   logic             same;
   logic [StabW-1:0] stable_nxt;
   logic             scan_end;
   logic             commit;

   // Column 0 starts from an empty accumulator instead of the previous scan's totals
   always_comb begin
      scan_cnt  = (col_idx_q == 2'd0) ? 2'd0 : acc_cnt_q;
      scan_code = (col_idx_q == 2'd0) ? 4'd0 : acc_code_q;
      for (int r = 0; r < 4; r++) begin
         if (!row[r]) begin
            scan_cnt  = (scan_cnt == 2'd2) ? 2'd2 : scan_cnt + 2'd1;
            scan_code = KeyMap[{2'(r), col_idx_q}];
         end
      end
   end

   always_comb begin
      res_kind = ResNone;
      res_code = 4'd0;
      if (scan_cnt == 2'd1) begin
         res_kind = ResKey;
         res_code = scan_code;
      end else if (scan_cnt == 2'd2) begin
         res_kind = ResMulti;
      end
      same       = (res_kind == last_kind_q) && (res_code == last_code_q);
      stable_nxt = same ? ((stable_q == StabMax) ? StabMax : stable_q + StabW'(1))
                        : StabW'(1);
      scan_end   = (div_q == DivLast) && (col_idx_q == 2'd3);
      // Commit only on the scan where the count first reaches the threshold
      commit     = scan_end && (stable_nxt == StabMax) && !(same && (stable_q == StabMax));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q       <= '0;
         col_idx_q   <= 2'd0;
         col_q       <= 4'b1110;
         acc_cnt_q   <= 2'd0;
         acc_code_q  <= 4'd0;
         last_kind_q <= ResNone;
         last_code_q <= 4'd0;
         stable_q    <= '0;
      end else if (div_q == DivLast) begin
         div_q      <= '0;
         col_idx_q  <= col_idx_q + 2'd1;
         col_q      <= {col_q[2:0], col_q[3]};
         acc_cnt_q  <= scan_cnt;
         acc_code_q <= scan_code;
         if (col_idx_q == 2'd3) begin
            last_kind_q <= res_kind;
            last_code_q <= res_code;
            stable_q    <= stable_nxt;
         end
      end else begin
         div_q <= div_q + DivW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdleOut;
         decode_q  <= 4'd0;
         pressed_q <= 1'b0;
         multi_q   <= 1'b0;
         pend_q    <= 4'd0;
      end else begin
         unique case (state_q)
            StIdleOut: begin
               if (commit) begin
                  unique case (res_kind)
                     ResKey: begin
                        state_q   <= StHeld;
                        decode_q  <= res_code;
                        pressed_q <= 1'b1;
                        multi_q   <= 1'b0;
                     end
                     ResMulti: multi_q <= 1'b1;
                     default:  multi_q <= 1'b0;
                  endcase
               end
            end
            StHeld: begin
               if (commit) begin
                  if (res_kind == ResKey) begin
                     // Key-to-key change goes through a one-cycle zero code
                     if (res_code != decode_q) begin
                        state_q   <= StGap;
                        decode_q  <= 4'd0;
                        pressed_q <= 1'b0;
                        pend_q    <= res_code;
                     end
                  end else begin
                     state_q   <= StIdleOut;
                     decode_q  <= 4'd0;
                     pressed_q <= 1'b0;
                     multi_q   <= (res_kind == ResMulti);
                  end
               end
            end
            StGap: begin
               state_q   <= StHeld;
               decode_q  <= pend_q;
               pressed_q <= 1'b1;
            end
            default: state_q <= StIdleOut;
         endcase
      end
   end

   assign col     = col_q;
   assign decode  = decode_q;
   assign pressed = pressed_q;
   assign multi   = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives rows from col, and a scoreboard
// holds the expected sequence of {decode, pressed, multi} changes.
module tb_keypad_scanner;

   localparam int unsigned ScanDiv  = 4;
   localparam int unsigned DebScans = 2;
   localparam int          Budget   = (DebScans + 1) * 4 * ScanDiv;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  decode;
   logic        pressed;
   logic        multi;

   logic [15:0] keys = '0;  // index row*4 + column
   logic [5:0]  exp_q [$];
   logic [5:0]  prev_out = '0;
   logic [5:0]  cur_out;
   logic [3:0]  exp_col;
   bit          mon_en = 1'b0;
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          chg_cyc = 0;
   int          prev_chg_cyc = 0;

   keypad_scanner #(
      .SCAN_DIV      (ScanDiv),
      .DEBOUNCE_SCANS(DebScans)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .row    (row),
      .col    (col),
      .decode (decode),
      .pressed(pressed),
      .multi  (multi)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
      end
   endtask

   function automatic logic [5:0] outv(input logic [3:0] d, input logic p, input logic m);
      return {d, p, m};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_sb(input string tag, input int budget);
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < budget) begin
         tick(1);
         i++;
      end
      check_val(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Every output change must match the next scoreboard entry
   always @(negedge clk) begin
      if (mon_en) begin
         cur_out = {decode, pressed, multi};
         if (cur_out !== prev_out) begin
            prev_chg_cyc = chg_cyc;
            chg_cyc      = cyc;
            if (exp_q.size() == 0) check_val("unexpected_change", cur_out, prev_out);
            else                   check_val("sb_output", cur_out, exp_q.pop_front());
            prev_out = cur_out;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset and column rotation
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_val("rst_col", col, 4'b1110);
      check_val("rst_decode", decode, 4'd0);
      check_val("rst_pressed", pressed, 1'b0);
      check_val("rst_multi", multi, 1'b0);
      rst      = 1'b0;
      prev_out = outv(4'd0, 1'b0, 1'b0);
      mon_en   = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         exp_col = ~(4'b0001 << ((k / 4) % 4));
         check_val("col_step", col, exp_col);
         tick(1);
      end

      // Key A press, hold, release
      keys[3] = 1'b1;
      exp_q.push_back(outv(4'hA, 1'b1, 1'b0));
      wait_sb("a_press", Budget);
      tick(200);
      check_val("a_hold", {decode, pressed, multi}, outv(4'hA, 1'b1, 1'b0));
      keys[3] = 1'b0;
      exp_q.push_back(outv(4'h0, 1'b0, 1'b0));
      wait_sb("a_release", Budget);

      // Key 5 contact closes for one cycle every 10 cycles, never two scans running
      for (int t = 0; t < 120; t++) begin
         keys[5] = (t % 10 == 0);
         tick(1);
      end
      keys[5] = 1'b0;
      tick(Budget);
      check_val("bounce_out", {decode, pressed, multi}, outv(4'h0, 1'b0, 1'b0));

      // Key 1 straight to key 4: one gap cycle
      keys[0] = 1'b1;
      exp_q.push_back(outv(4'h1, 1'b1, 1'b0));
      wait_sb("one_press", Budget);
      keys[0] = 1'b0;
      keys[4] = 1'b1;
      exp_q.push_back(outv(4'h0, 1'b0, 1'b0));
      exp_q.push_back(outv(4'h4, 1'b1, 1'b0));
      wait_sb("one_to_four", Budget);
      check_val("gap_len", chg_cyc - prev_chg_cyc, 1);
      keys[4] = 1'b0;
      exp_q.push_back(outv(4'h0, 1'b0, 1'b0));
      wait_sb("four_release", Budget);

      // Keys 2 and 3 together, then release 3
      keys[1] = 1'b1;
      keys[2] = 1'b1;
      exp_q.push_back(outv(4'h0, 1'b0, 1'b1));
      wait_sb("multi_press", Budget);
      keys[2] = 1'b0;
      exp_q.push_back(outv(4'h2, 1'b1, 1'b0));
      wait_sb("multi_to_two", Budget);
      keys[1] = 1'b0;
      exp_q.push_back(outv(4'h0, 1'b0, 1'b0));
      wait_sb("two_release", Budget);

      // Reset while key D is held
      keys[15] = 1'b1;
      exp_q.push_back(outv(4'hD, 1'b1, 1'b0));
      wait_sb("d_press", Budget);
      exp_q.push_back(outv(4'h0, 1'b0, 1'b0));
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check_val("rst_mid_out", {decode, pressed, multi}, outv(4'h0, 1'b0, 1'b0));
      check_val("rst_mid_col", col, 4'b1110);
      check_val("rst_mid_sb", exp_q.size(), 0);
      exp_q.push_back(outv(4'hD, 1'b1, 1'b0));
      wait_sb("d_recommit", Budget);
      keys[15] = 1'b0;
      exp_q.push_back(outv(4'h0, 1'b0, 1'b0));
      wait_sb("d_release", Budget);
      tick(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
